// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier controller.
// Build option: SEQ_MULT_ZERO_BYPASS_EN (zero-operand shortcut).
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Operand/result valid-ready bundle between producer, multiplier and consumer.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = seq_mult_pkg::WIDTH_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/bit4_adder.sv
// 4-bit ripple-carry adder, the shared datapath adder of the multiplier.
module bit4_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_carry_out
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign o_sum[gi]   = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_carry_out = w_c[4];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one shared adder, WIDTH iterations.
// Build option: SEQ_MULT_ZERO_BYPASS_EN sends zero-operand jobs straight to DONE.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  seq_mult_ctrl_if.slave  bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic               w_accept;
  logic               w_last;
  logic               w_bypass;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;

`ifdef SEQ_MULT_ZERO_BYPASS_EN
  assign w_bypass = (bus.a == '0) || (bus.b == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_addend = r_q[0] ? r_m : '0;

  // r_c is cleared by every shift, so it always presents a zero carry-in.
  bit4_adder u_adder (
    .i_a         (r_a),
    .i_b         (w_addend),
    .i_cin       (r_c),
    .o_sum       (w_sum),
    .o_carry_out (w_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_state_next = w_bypass ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // in_ready is masked by rst so it stays low for the whole reset assertion.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE:    w_in_ready  = ~rst;
      RUN:     w_busy      = 1'b1;
      DONE: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
      end
      default: w_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m   <= '0;
      r_a   <= '0;
      r_q   <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_m   <= bus.a;
      r_a   <= '0;
      r_q   <= w_bypass ? '0 : bus.b;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      // Carry-out lands in A's MSB after the right shift, so 15*15 stays exact.
      r_a   <= {w_carry, w_sum[WIDTH-1:1]};
      r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
      r_c   <= 1'b0;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.product   = {r_a, r_q};

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and exhaustive scoreboard bench for seq_mult_ctrl.
module tb_seq_mult_ctrl;

  localparam int W = 4;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [2*W-1:0] sb_q[$];

  seq_mult_ctrl_if #(.WIDTH(W)) bus ();

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges counted from the cycle operands are presented; the accept edge is edge 1.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int stall, input bit noise);
    int             lat;
    int             exp_lat;
    logic [2*W-1:0] exp_p;
    exp_lat = (BYP && (ta == '0 || tb_v == '0)) ? 1 : W + 1;
    chk("idle_in_ready", 16'(bus.in_ready), 16'd1);
    bus.in_valid  = 1'b1;
    bus.a         = ta;
    bus.b         = tb_v;
    bus.out_ready = (stall == 0);
    sb_q.push_back({{W{1'b0}}, ta} * {{W{1'b0}}, tb_v});
    tick();
    lat = 1;
    if (noise) begin
      bus.a = 4'hF;
      bus.b = 4'hF;
    end else begin
      bus.in_valid = 1'b0;
    end
    while (bus.out_valid !== 1'b1 && lat < 4 * W) begin
      chk("run_ready_busy", 16'({bus.in_ready, bus.busy}), 16'b01);
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("out_valid_rise", 16'(bus.out_valid), 16'd1);
    chk("latency", 16'(lat), 16'(exp_lat));
    chk("done_ready_busy", 16'({bus.in_ready, bus.busy}), 16'b01);
    chk("sb_nonempty", 16'(sb_q.size() != 0), 16'd1);
    exp_p = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    chk($sformatf("product_%0d_x_%0d", ta, tb_v), 16'(bus.product), 16'(exp_p));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("hold_product", 16'(bus.product), 16'(exp_p));
      chk("hold_valid_ready", 16'({bus.out_valid, bus.in_ready}), 16'b10);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("post_handshake", 16'({bus.out_valid, bus.in_ready, bus.busy}), 16'b010);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_product", 16'(bus.product), 16'd0);
    rst = 1'b0;
    tick();
    chk("release_in_ready", 16'(bus.in_ready), 16'd1);

    run_txn(4'd3, 4'd5, 0, 1'b0);
    run_txn(4'd15, 4'd15, 0, 1'b0);
    run_txn(4'd9, 4'd6, 10, 1'b1);

    // Abort a job two cycles into RUN; its result must never appear.
    bus.in_valid = 1'b1;
    bus.a        = 4'd7;
    bus.b        = 4'd7;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrun_rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("midrun_rst_busy", 16'(bus.busy), 16'd0);
    chk("midrun_rst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("midrun_rst_product", 16'(bus.product), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    run_txn(4'd2, 4'd3, 0, 1'b0);

    run_txn(4'd0, 4'd11, 0, 1'b0);

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_txn(4'(ia), 4'(ib), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end
    end

    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
